data_io_sched: RTL and testbench

- Time-multiplexing scheduler for the data I/O block's connection-select vector `c`.
- Holds a small programmable schedule of connection slots. Each slot asserts exactly one `c` bit, which connects one external lane onto one data-bus wire.
- Steps through the slots with programmable dwell and a one-cycle break-before-make gap, so no two tri-state drivers ever overlap on `data`.
- Sits between the host or config logic and the `c` input of the data I/O block.

---
 rtl/data_io_sched_if.sv | 36 +++
 rtl/data_io_sched.sv | 143 ++++++++++++++
 tb/tb_data_io_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_io_sched_if.sv
// Host-side bus of the data I/O connection scheduler: program load handshake,
// run control and the registered connection-select/status outputs.
interface data_io_sched_if #(
  parameter int unsigned W          = 12,
  parameter int unsigned EXTDATAIN  = 3,
  parameter int unsigned EXTDATAOUT = 2,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned CW   = W * (EXTDATAIN + EXTDATAOUT);
  localparam int unsigned IDXW = $clog2(CW);
  localparam int unsigned SW   = $clog2(DEPTH);

  logic            prog_valid;
  logic            prog_ready;
  logic [IDXW:0]   prog_data;
  logic            prog_last;
  logic            start;
  logic            stop;
  logic            loop;
  logic [3:0]      dwell;
  logic [CW-1:0]   c;
  logic [SW-1:0]   slot;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output prog_valid, prog_data, prog_last, start, stop, loop, dwell,
    input  prog_ready, c, slot, busy, done, err
  );

  modport slave (
    input  prog_valid, prog_data, prog_last, start, stop, loop, dwell,
    output prog_ready, c, slot, busy, done, err
  );
endinterface

// File: rtl/data_io_sched.sv
// Time-multiplexing scheduler for the data I/O connection-select vector c.
// Steps through a programmed list of one-hot slots, holding each for dwell+1
// cycles and inserting a one-cycle all-zero gap so tri-state drivers on the
// data bus never overlap.
module data_io_sched #(
  parameter int unsigned W          = 12,
  parameter int unsigned EXTDATAIN  = 3,
  parameter int unsigned EXTDATAOUT = 2,
  parameter int unsigned DEPTH      = 8
) (
  input logic            clk,
  input logic            reset,
  data_io_sched_if.slave bus
);
  localparam int unsigned CW   = W * (EXTDATAIN + EXTDATAOUT);
  localparam int unsigned IDXW = $clog2(CW);
  localparam int unsigned SW   = $clog2(DEPTH);
  localparam logic [IDXW:0] CwLim = CW[IDXW:0];

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e          state_q;
  logic [IDXW:0]   mem [DEPTH];
  logic [SW-1:0]   wr_ptr_q;
  logic [SW-1:0]   slot_q;
  logic [SW:0]     len_q;
  logic            loop_q;
  logic [3:0]      dwell_q;
  logic [3:0]      cnt_q;
  logic [CW-1:0]   c_q;
  logic            done_q;
  logic            err_q;

  logic            accept;
  logic            last_beat;
  logic            start_ok;
  logic            at_end;
  logic [SW-1:0]   next_slot;
  logic [IDXW:0]   first_entry;
  logic [IDXW:0]   next_entry;

  // Enabled entry whose index points past the end of c.
  function automatic logic entry_bad(logic [IDXW:0] e);
    return e[IDXW] && ({1'b0, e[IDXW-1:0]} >= CwLim);
  endfunction

  // One-hot select for a valid enabled entry, otherwise nothing connected.
  function automatic logic [CW-1:0] entry_sel(logic [IDXW:0] e);
    logic [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    if (e[IDXW] && !entry_bad(e)) return one << e[IDXW-1:0];
    return '0;
  endfunction

  assign bus.prog_ready = (state_q == StIdle) && !bus.start;
  assign accept         = bus.prog_valid && bus.prog_ready;
  assign last_beat      = bus.prog_last || (wr_ptr_q == SW'(DEPTH - 1));
  assign start_ok       = (state_q == StIdle) && bus.start && !bus.stop && (len_q != '0);
  assign at_end         = ({1'b0, slot_q} == len_q - (SW + 1)'(1));
  assign next_slot      = at_end ? '0 : slot_q + SW'(1);
  assign first_entry    = mem['0];
  assign next_entry     = mem[next_slot];

  assign bus.c    = c_q;
  assign bus.slot = slot_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  // Schedule memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.prog_data;
  end

  // Program length tracking and run FSM with registered c/slot/done/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      c_q      <= '0;
      slot_q   <= '0;
      wr_ptr_q <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (last_beat) begin
              len_q    <= {1'b0, wr_ptr_q} + (SW + 1)'(1);
              wr_ptr_q <= '0;
            end else begin
              wr_ptr_q <= wr_ptr_q + SW'(1);
            end
          end
          if (start_ok) begin
            state_q  <= StOn;
            slot_q   <= '0;
            loop_q   <= bus.loop;
            dwell_q  <= bus.dwell;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            c_q      <= entry_sel(first_entry);
            err_q    <= entry_bad(first_entry);
          end
        end
        StOn: begin
          if (bus.stop) begin
            state_q <= StIdle;
            c_q     <= '0;
            slot_q  <= '0;
          end else if (cnt_q == dwell_q) begin
            state_q <= StGap;
            c_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StGap: begin
          if (bus.stop) begin
            state_q <= StIdle;
            slot_q  <= '0;
          end else if (!at_end || loop_q) begin
            state_q <= StOn;
            slot_q  <= next_slot;
            cnt_q   <= '0;
            c_q     <= entry_sel(next_entry);
            if (entry_bad(next_entry)) err_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            slot_q  <= '0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_data_io_sched.sv
// Directed bench for data_io_sched: cycle-exact c/slot/busy/done/err checks.
module tb_data_io_sched;
  localparam int unsigned CW = 60;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_io_sched_if #(.W(12), .EXTDATAIN(3), .EXTDATAOUT(2), .DEPTH(8)) bus ();

  data_io_sched #(.W(12), .EXTDATAIN(3), .EXTDATAOUT(2), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit en, input int idx, input bit last);
    bus.prog_valid = 1'b1;
    bus.prog_data  = {en, 6'(idx)};
    bus.prog_last  = last;
    step();
    bus.prog_valid = 1'b0;
    bus.prog_last  = 1'b0;
  endtask

  task automatic go(input logic [3:0] d, input bit lp);
    bus.dwell = d;
    bus.loop  = lp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  function automatic logic [CW-1:0] oh(input int k);
    logic [CW-1:0] one;
    one = 60'd1;
    return one << k;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.c !== '0) begin n_fail++; $display("FAIL reset_c: got %h expected 0", bus.c); end
    n_checks++;
    if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d expected 0", bus.slot); end
    n_checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.err});
    end
    n_checks++;
    if (bus.prog_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.prog_ready); end
    go(4'd0, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_start: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic_run();
    logic [CW-1:0] exp_c [9];
    exp_c = '{oh(0), oh(0), '0, oh(13), oh(13), '0, oh(59), oh(59), '0};
    load(1'b1, 0, 1'b0);
    load(1'b1, 13, 1'b0);
    load(1'b1, 59, 1'b1);
    go(4'd1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (bus.c !== exp_c[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: got c=%h busy=%b done=%b expected c=%h busy=1 done=0",
                 i, bus.c, bus.busy, bus.done, exp_c[i]);
      end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.c !== '0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b busy=%b c=%h expected done=1 busy=0 c=0",
               bus.done, bus.busy, bus.c);
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_err();
    bit exp_err [5];
    exp_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load(1'b0, 5, 1'b0);
    load(1'b1, 60, 1'b1);
    go(4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.c !== '0 || bus.err !== exp_err[i] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL err_cycle%0d: got c=%h err=%b busy=%b expected c=0 err=%b busy=1",
                 i, bus.c, bus.err, bus.busy, exp_err[i]);
      end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.err !== exp_err[4]) begin
      n_fail++; $display("FAIL err_done: got done=%b err=%b expected done=1 err=1", bus.done, bus.err);
    end
    go(4'd0, 1'b0);
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL err_clear: got err=%b busy=%b expected err=0 busy=1", bus.err, bus.busy);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL err_stop: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_loop_stop();
    logic [CW-1:0] exp_c [7];
    logic [2:0]    exp_s [7];
    exp_c = '{oh(2), '0, oh(40), '0, oh(2), '0, oh(40)};
    exp_s = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
    load(1'b1, 2, 1'b0);
    load(1'b1, 40, 1'b1);
    go(4'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (bus.c !== exp_c[i] || bus.slot !== exp_s[i]) begin
        n_fail++;
        $display("FAIL loop_cycle%0d: got c=%h slot=%0d expected c=%h slot=%0d",
                 i, bus.c, bus.slot, exp_c[i], exp_s[i]);
      end
      if (i < 6) step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_checks++;
    if (bus.c !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.slot !== 3'd0) begin
      n_fail++;
      $display("FAIL loop_stop: got c=%h busy=%b done=%b slot=%0d expected c=0 busy=0 done=0 slot=0",
               bus.c, bus.busy, bus.done, bus.slot);
    end
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 8; i++) load(1'b1, 7 * i, 1'b0);
    go(4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.c !== oh(7 * i) || bus.slot !== 3'(i)) begin
        n_fail++;
        $display("FAIL depth_on%0d: got c=%h slot=%0d expected c=%h slot=%0d",
                 i, bus.c, bus.slot, oh(7 * i), i);
      end
      step();
      n_checks++;
      if (bus.c !== '0 || bus.slot !== 3'(i)) begin
        n_fail++;
        $display("FAIL depth_gap%0d: got c=%h slot=%0d expected c=0 slot=%0d", i, bus.c, bus.slot, i);
      end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL depth_done: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    load(1'b1, 3, 1'b1);
    go(4'd3, 1'b0);
    n_checks++;
    if (bus.c !== oh(3)) begin n_fail++; $display("FAIL midrst_on: got %h expected %h", bus.c, oh(3)); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.c !== '0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst: got c=%h busy=%b expected c=0 busy=0", bus.c, bus.busy);
    end
    go(4'd0, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.c !== '0) begin
      n_fail++; $display("FAIL midrst_restart: got busy=%b c=%h expected busy=0 c=0", bus.busy, bus.c);
    end
  endtask

  task automatic test_valid_with_start();
    load(1'b1, 9, 1'b1);
    bus.prog_valid = 1'b1;
    bus.prog_data  = {1'b1, 6'd20};
    bus.prog_last  = 1'b1;
    bus.dwell      = 4'd0;
    bus.loop       = 1'b0;
    bus.start      = 1'b1;
    #1;
    n_checks++;
    if (bus.prog_ready !== 1'b0) begin n_fail++; $display("FAIL vs_ready: got %b expected 0", bus.prog_ready); end
    step();
    bus.prog_valid = 1'b0;
    bus.prog_last  = 1'b0;
    bus.start      = 1'b0;
    n_checks++;
    if (bus.c !== oh(9) || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL vs_run: got c=%h busy=%b expected c=%h busy=1", bus.c, bus.busy, oh(9));
    end
    step();
    step();
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL vs_done: got %b expected 1", bus.done); end
    go(4'd0, 1'b0);
    n_checks++;
    if (bus.c !== oh(9)) begin n_fail++; $display("FAIL vs_rerun: got %h expected %h", bus.c, oh(9)); end
    step();
    step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.prog_valid = 1'b0;
    bus.prog_data  = '0;
    bus.prog_last  = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.loop       = 1'b0;
    bus.dwell      = 4'd0;
    test_reset();
    test_basic_run();
    test_err();
    test_loop_stop();
    test_full_depth();
    test_reset_mid_run();
    test_valid_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
